// File: rtl/wb_pkg.sv
// Shared FSM/termination types and per-instance width helpers for the Wishbone slave memory.
// Definitions only: no latency, no flow control.
// Widths depend on instance parameters, so helpers are functions rather than fixed constants.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_state_t;

    typedef enum logic [1:0] {
        RESP_ACK,
        RESP_ERR,
        RESP_RTY
    } wb_resp_t;

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int word_off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    localparam int DEF_LANES    = lane_cnt(32);
    localparam int DEF_OFF_BITS = word_off_bits(32);

endpackage

// File: rtl/wb_slave_bytemem.sv
// Byte-enabled DEPTH x DATA_W word store: one write port, combinational read on the same index.
// Write lands on the clock edge; read is zero-latency.
// No backpressure; contents are never reset.
module wb_slave_bytemem
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdat,
    input  logic [DATA_W/8-1:0]      wsel,
    output logic [DATA_W-1:0]        rdat
);

    localparam int LANES = lane_cnt(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wsel[i]) begin
                    mem[idx][8*i +: 8] <= wdat[8*i +: 8];
                end
            end
        end
    end

    assign rdat = mem[idx];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic slave over a byte-enabled RAM with wait states, ERR range check and RTY injection.
// Termination appears WAIT_STATES+1 cycles after the accepting edge; one access per WAIT_STATES+2 cycles.
// Stalls the master by withholding termination; dropping CYC/STB while waiting aborts the access.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                TAG_W       = 16,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    parameter int                RTY_EVERY   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CYC_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [ADDR_W-1:0]   ADR_I,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic [DATA_W/8-1:0] SEL_I,
    input  logic                LOCK_I,
    input  logic [TAG_W-1:0]    TGA_I,
    input  logic [TAG_W-1:0]    TGC_I,
    input  logic [TAG_W-1:0]    TGD_I,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [TAG_W-1:0]    TGD_O,
    output logic                ACK_O,
    output logic                ERR_O,
    output logic                RTY_O
);

    localparam int LANES = lane_cnt(DATA_W);
    localparam int OFF_W = word_off_bits(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (RTY_EVERY > 1) ? $clog2(RTY_EVERY) : 1;

    localparam logic [ADDR_W-1:0] SPAN_MASK = ADDR_W'(DEPTH * LANES - 1);
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [CNT_W-1:0]  RTY_LAST  = CNT_W'(RTY_EVERY - 1);

    typedef struct packed {
        logic               we;
        logic               lock;
        wb_resp_t           cls;
        logic [ADDR_W-1:0]  adr;
        logic [DATA_W-1:0]  dat;
        logic [LANES-1:0]   sel;
        logic [TAG_W-1:0]   tgd;
    } req_t;

    wb_state_t         state;
    logic [3:0]        wait_cnt;
    logic [CNT_W-1:0]  rty_cnt;
    req_t              req_q;
    req_t              req_in;
    req_t              req_cur;

    logic              req;
    logic              in_range;
    logic              aligned;
    logic              rty_fire;
    logic              go_resp;
    logic              mem_we;
    logic [ADDR_W-1:0] rel_cur;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdat;
    logic [DATA_W-1:0] rd_masked;

    assign req      = CYC_I & STB_I;
    // BASE_ADDR is span-aligned, so range membership is an upper-bit compare.
    assign in_range = (ADR_I & ~SPAN_MASK) == BASE_ADDR;
    assign aligned  = ADR_I[OFF_W-1:0] == '0;
    assign rty_fire = (RTY_EVERY > 0) && !LOCK_I && (rty_cnt == RTY_LAST);

    always_comb begin
        req_in      = '0;
        req_in.we   = WE_I;
        req_in.lock = LOCK_I;
        req_in.adr  = ADR_I;
        req_in.dat  = DAT_I;
        req_in.sel  = SEL_I;
        req_in.tgd  = TGD_I;
        if (!in_range || !aligned || SEL_I == '0) begin
            req_in.cls = RESP_ERR;
        end else if (rty_fire) begin
            req_in.cls = RESP_RTY;
        end else begin
            req_in.cls = RESP_ACK;
        end
    end

    // Zero wait states terminate straight from the accepting edge, so use the live request there.
    assign req_cur = (state == IDLE) ? req_in : req_q;
    assign go_resp = req && (((state == IDLE) && (WAIT_STATES == 0)) ||
                             ((state == WAIT) && (wait_cnt == 4'd0)));
    assign rel_cur = req_cur.adr - BASE_ADDR;
    assign mem_idx = rel_cur[OFF_W +: IDX_W];
    assign mem_we  = go_resp && req_cur.we && (req_cur.cls == RESP_ACK) && !rst;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign rd_masked[8*i +: 8] = req_cur.sel[i] ? mem_rdat[8*i +: 8] : 8'h00;
    end

    wb_slave_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .idx  (mem_idx),
        .wdat (req_cur.dat),
        .wsel (req_cur.sel),
        .rdat (mem_rdat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rty_cnt  <= '0;
            req_q    <= '0;
            ACK_O    <= 1'b0;
            ERR_O    <= 1'b0;
            RTY_O    <= 1'b0;
            DAT_O    <= '0;
            TGD_O    <= '0;
        end else begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            RTY_O <= 1'b0;
            DAT_O <= '0;
            TGD_O <= '0;

            // Retry bookkeeping commits only at termination so aborted accesses leave it untouched.
            if (go_resp) begin
                ACK_O <= req_cur.cls == RESP_ACK;
                ERR_O <= req_cur.cls == RESP_ERR;
                RTY_O <= req_cur.cls == RESP_RTY;
                TGD_O <= req_cur.tgd;
                if (req_cur.cls == RESP_ACK && !req_cur.we) begin
                    DAT_O <= rd_masked;
                end
                if (req_cur.cls == RESP_RTY) begin
                    rty_cnt <= '0;
                end else if (req_cur.cls == RESP_ACK && !req_cur.lock) begin
                    rty_cnt <= rty_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        req_q    <= req_in;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{TGA_I, TGC_I, rel_cur};

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: a zero-wait instance and a 3-wait/retry-every-3 instance at base 0x2000,
// driven by directed and random accesses checked against a byte-array memory and access-count model.
module tb_wb_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we, lock;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic [15:0] tga, tgc, tgd;
    int          dsel;

    logic [31:0] dat_o_a, dat_o_b, dat_o;
    logic [15:0] tgd_o_a, tgd_o_b, tgd_o;
    logic        ack_a, err_a, rty_a, ack_b, err_b, rty_b;
    logic        ack_o, err_o, rty_o;

    wb_slave_mem u_a (
        .clk(clk), .rst(rst),
        .CYC_I(cyc && dsel == 0), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat_w),
        .SEL_I(sel), .LOCK_I(lock), .TGA_I(tga), .TGC_I(tgc), .TGD_I(tgd),
        .DAT_O(dat_o_a), .TGD_O(tgd_o_a), .ACK_O(ack_a), .ERR_O(err_a), .RTY_O(rty_a)
    );

    wb_slave_mem #(
        .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3), .RTY_EVERY(3)
    ) u_b (
        .clk(clk), .rst(rst),
        .CYC_I(cyc && dsel == 1), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat_w),
        .SEL_I(sel), .LOCK_I(lock), .TGA_I(tga), .TGC_I(tgc), .TGD_I(tgd),
        .DAT_O(dat_o_b), .TGD_O(tgd_o_b), .ACK_O(ack_b), .ERR_O(err_b), .RTY_O(rty_b)
    );

    assign ack_o = (dsel == 1) ? ack_b   : ack_a;
    assign err_o = (dsel == 1) ? err_b   : err_a;
    assign rty_o = (dsel == 1) ? rty_b   : rty_a;
    assign dat_o = (dsel == 1) ? dat_o_b : dat_o_a;
    assign tgd_o = (dsel == 1) ? tgd_o_b : tgd_o_a;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: byte image per instance and count of retry-eligible accesses.
    logic [7:0]  bm [2][1024];
    int          elig [2];
    int          last_term;
    logic [31:0] last_rd;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h0000_2000 : 32'h0;
    endfunction

    function automatic int rty_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0; sel = '0;
    endtask

    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit lk, input bit b2b,
                             input logic [15:0] tg);
        longint unsigned ua, ub;
        int              off, cls, t0, exp_t;
        bit              got;
        logic [31:0]     exp_rd;
        logic [2:0]      exp_term;
        if (!b2b) begin
            release_bus();
            @(negedge clk);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; lock = lk; tgd = tg;
        tga = 16'($urandom); tgc = 16'($urandom);
        t0 = cyc_cnt;

        ua = a;
        ub = base_of(dsel);
        off = int'(ua - ub);
        exp_rd = '0;
        if (ua < ub || ua >= ub + 1024 || ua % 4 != 0 || s == 4'h0) begin
            cls = 1;
        end else begin
            cls = 0;
            if (!lk && rty_of(dsel) > 0) begin
                elig[dsel]++;
                if (elig[dsel] % rty_of(dsel) == 0) cls = 2;
            end
        end
        if (cls == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    if (w) bm[dsel][off + i] = d[8*i +: 8];
                    else   exp_rd[8*i +: 8] = bm[dsel][off + i];
                end
            end
        end
        exp_term = (cls == 0) ? 3'b100 : (cls == 1) ? 3'b010 : 3'b001;
        exp_t    = t0 + 1 + ws_of(dsel) + (b2b ? 1 : 0);

        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (ack_o || err_o || rty_o) got = 1'b1;
            else chk("quiet_out", {dat_o, tgd_o}, 64'h0);
        end
        chk("term_seen", got, 1);
        if (got) begin
            chk("latency", cyc_cnt, exp_t);
            chk("term", {ack_o, err_o, rty_o}, exp_term);
            chk("tgd_echo", tgd_o, tg);
            if (!w || cls != 0) chk("dat_o", dat_o, exp_rd);
        end
        last_term = rty_o ? 2 : err_o ? 1 : 0;
        last_rd   = dat_o;
    endtask

    function automatic logic [31:0] rand_adr(input int d);
        int          r;
        logic [31:0] b;
        r = $urandom_range(0, 19);
        b = base_of(d);
        if (r == 0) return $urandom;
        if (r == 1) return b + ($urandom_range(0, 1023) | 1);
        if (r == 2) return b + 32'd1024 + 4 * $urandom_range(0, 7);
        return b + 4 * $urandom_range(0, 255);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pat;
        int          d;
        bit          held;
        logic [31:0] b;

        rst = 1'b1; dsel = 0; tga = '0; tgc = '0; tgd = '0; adr = '0; dat_w = '0;
        release_bus();
        elig[0] = 0; elig[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a", {ack_a, err_a, rty_a, dat_o_a, tgd_o_a}, 64'h0);
        chk("rst_b", {ack_b, err_b, rty_b, dat_o_b, tgd_o_b}, 64'h0);

        // Fill both memories (locked, so the retry sequence is not disturbed).
        for (int di = 0; di < 2; di++) begin
            dsel = di;
            for (int wi = 0; wi < 256; wi++)
                do_access(1, base_of(di) + 4 * wi, $urandom, 4'hF, 1, 0, 16'($urandom));
        end

        // Zero-wait instance: basic write/read, lane masking, ERR cases.
        dsel = 0;
        do_access(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 16'h5A5A);
        do_access(0, 32'h10, 32'h0, 4'hF, 0, 0, 16'h5A5A);
        chk("plan_rd", last_rd, 32'hDEADBEEF);
        do_access(1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 16'h0001);
        do_access(1, 32'h20, 32'h11223344, 4'h5, 0, 0, 16'h0002);
        do_access(0, 32'h20, 32'h0, 4'hF, 0, 0, 16'h0003);
        chk("plan_lane_f", last_rd, 32'hFF22FF44);
        do_access(0, 32'h20, 32'h0, 4'h3, 0, 0, 16'h0004);
        chk("plan_lane_3", last_rd, 32'h0000FF44);
        do_access(1, 32'h400, 32'h12345678, 4'hF, 0, 0, 16'h0005);
        chk("plan_err_range", last_term, 1);
        do_access(1, 32'h13, 32'h87654321, 4'hF, 0, 0, 16'h0006);
        chk("plan_err_align", last_term, 1);
        do_access(1, 32'h10, 32'h55555555, 4'h0, 0, 0, 16'h0007);
        chk("plan_err_sel0", last_term, 1);
        do_access(0, 32'h0, 32'h0, 4'hF, 0, 0, 16'h0008);
        do_access(0, 32'h10, 32'h0, 4'hF, 0, 0, 16'h0009);
        chk("plan_err_nowrite", last_rd, 32'hDEADBEEF);

        // Wait-state/retry instance.
        dsel = 1;
        b = base_of(1);
        pat = 0;
        for (int i = 0; i < 6; i++) begin
            do_access(1, b + 4 * i, $urandom, 4'hF, 0, 0, 16'($urandom));
            if (last_term == 2) pat |= (1 << i);
        end
        chk("plan_rty_pat", pat, 6'b100100);
        pat = 0;
        for (int i = 0; i < 6; i++) begin
            do_access(1, b + 4 * i, $urandom, 4'hF, 1, 0, 16'($urandom));
            if (last_term != 0) pat |= (1 << i);
        end
        chk("plan_lock_all_ack", pat, 0);

        // Abort after two wait cycles: no termination, no write, retry count untouched.
        release_bus();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = b + 32'h40; dat_w = 32'hA5A5_0000;
        sel = 4'hF; lock = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_quiet", {ack_b, err_b, rty_b}, 3'b000);
        end
        cyc = 1'b0;
        do_access(0, b + 32'h40, 32'h0, 4'hF, 1, 0, 16'h1111);
        pat = 0;
        for (int i = 0; i < 3; i++) begin
            do_access(1, b + 32'h100 + 4 * i, $urandom, 4'hF, 0, 0, 16'($urandom));
            if (last_term == 2) pat |= (1 << i);
        end
        chk("abort_cnt_kept", pat, 3'b100);

        // Back-to-back strobes: each follow-on access terminates WAIT_STATES+2 cycles later.
        do_access(0, b + 32'h0, 32'h0, 4'hF, 1, 0, 16'h2001);
        do_access(0, b + 32'h4, 32'h0, 4'hF, 1, 1, 16'h2002);
        do_access(0, b + 32'h8, 32'h0, 4'hC, 1, 1, 16'h2003);

        // Reset on the edge that would have entered RESP for a write.
        do_access(1, b + 32'h200, $urandom, 4'hF, 0, 0, 16'h3001);
        release_bus();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = b + 32'h80; dat_w = 32'h0BAD_F00D;
        sel = 4'hF; lock = 1'b0; tgd = 16'h3002;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", {ack_b, err_b, rty_b, dat_o_b, tgd_o_b}, 64'h0);
        rst = 1'b0;
        release_bus();
        elig[0] = 0; elig[1] = 0;
        do_access(0, b + 32'h80, 32'h0, 4'hF, 1, 0, 16'h3003);
        pat = 0;
        for (int i = 0; i < 3; i++) begin
            do_access(1, b + 32'h300 + 4 * i, $urandom, 4'hF, 0, 0, 16'($urandom));
            if (last_term == 2) pat |= (1 << i);
        end
        chk("rst_cnt_clear", pat, 3'b100);

        // Random traffic over both instances.
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            d = $urandom_range(0, 1);
            if (d == dsel && held && $urandom_range(0, 1) == 1) begin
                do_access($urandom_range(0, 1), rand_adr(d), $urandom, 4'($urandom),
                          $urandom_range(0, 3) == 0, 1, 16'($urandom));
            end else begin
                release_bus();
                dsel = d;
                do_access($urandom_range(0, 1), rand_adr(d), $urandom, 4'($urandom),
                          $urandom_range(0, 3) == 0, 0, 16'($urandom));
            end
            held = 1'b1;
        end

        release_bus();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Parametrised Wishbone B4 classic-cycle slave backed by an internal byte-enabled word memory. It is the synthesizable successor to our testbench-only slave interface, with generalised data width and tag widths, programmable wait states, address-range ERR termination and deterministic RTY injection. It serves as the reference target for the Wishbone master agents and as a drop-in scratch RAM in the DUT-side environment.

## Interface
- DATA_W, 32: data bus width; 32 or 64.
- ADDR_W, 32: byte-address width.
- TAG_W, 16: width of TGA/TGC/TGD tags.
- DEPTH, 256: memory depth in DATA_W words; power of two.
- BASE_ADDR, 0: byte address of word 0; aligned to DEPTH*DATA_W/8.
- WAIT_STATES, 0: extra cycles inserted before termination; 0..15.
- RTY_EVERY, 0: 0 disables retry; N>=2 retries every Nth eligible access.

- clk  in  1  bus clock.
- rst  in  1  synchronous, active-high reset.
- CYC_I  in  1  cycle valid.
- STB_I  in  1  strobe.
- WE_I  in  1  1 = write.
- ADR_I  in  ADDR_W  byte address.
- DAT_I  in  DATA_W  write data.
- SEL_I  in  DATA_W/8  byte lane enables.
- LOCK_I  in  1  locked sequence; suppresses retry.
- TGA_I, TGC_I, TGD_I  in  TAG_W  address/cycle/data tags.
- DAT_O  out  DATA_W  read data.
- TGD_O  out  TAG_W  data tag echo.
- ACK_O, ERR_O, RTY_O  out  1  terminations; at most one high per cycle.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on CYC_I & STB_I, capture ADR_I, WE_I, DAT_I, SEL_I, TGD_I; classify; go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: down-counter loaded with WAIT_STATES-1 at accept; at 0 go to RESP. If CYC_I or STB_I drops in WAIT: abort to IDLE, no termination, no write, retry counter unchanged.
- RESP: exactly one termination high for one cycle; always returns to IDLE. RESP never accepts a new access.
- Classification (priority order): ERR if ADR_I outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8), ADR_I low bits not word-aligned, or SEL_I == 0; else RTY if RTY_EVERY>0, LOCK_I==0 and retry counter == RTY_EVERY-1; else ACK.
- Retry counter: increments on each accepted non-ERR, non-locked access; wraps to 0 when RTY fires. Locked and ERR accesses neither increment nor fire.
- Word index = (ADR_I - BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH) bits.
- Write: memory updated only for ACK terminations, only lanes with SEL bit set, on the clk edge entering RESP.
- Read: DAT_O valid during ACK cycle; lanes with SEL bit 0 drive 0. DAT_O is 0 during ERR/RTY and all non-RESP cycles.
- TGD_O = captured TGD_I during any RESP cycle, else 0. TGA_I/TGC_I are accepted and ignored.

## Timing
- All outputs registered. Reset values: ACK_O/ERR_O/RTY_O = 0, DAT_O = 0, TGD_O = 0, state IDLE, wait and retry counters 0. Memory contents not reset.
- Latency: request sampled at edge n; termination high in cycle n+1+WAIT_STATES.
- Throughput: one access per WAIT_STATES+2 cycles for back-to-back strobes.
- rst mid-access (WAIT or RESP): next cycle IDLE, outputs 0, pending write discarded.
- Master holding STB_I after termination starts a new access at the next IDLE edge (intended classic behaviour).

## Structure
- Package wb_pkg: state enum (IDLE/WAIT/RESP), termination enum (RESP_ACK/RESP_ERR/RESP_RTY), localparams for byte-lane count and word-offset bits derived per instance via functions.
- Sub-module wb_slave_bytemem: DEPTH x DATA_W array, one write port with byte enables, combinational read; instantiated once.

## Test plan
- Defaults, write 0xDEADBEEF to 0x10 SEL=0xF, read 0x10 -> ACK in cycle n+1 both, DAT_O=0xDEADBEEF, TGD_O echoes 0x5A5A.
- Write 0x11223344 SEL=0x5 over 0xFFFFFFFF, read SEL=0xF -> 0xFF22FF44; read SEL=0x3 -> 0x0000FF44.
- Access 0x400 (DEPTH=256) and 0x13 -> ERR_O one cycle, DAT_O=0, memory unchanged.
- WAIT_STATES=3, back-to-back reads -> ACK at n+4, next accept at n+5, ACK at n+9; drop STB after 2 wait cycles -> no termination, FSM IDLE.
- RTY_EVERY=3, six writes with LOCK_I=0 -> accesses 3 and 6 get RTY with no write; repeat with LOCK_I=1 -> all ACK, counter unchanged.
- rst asserted in WAIT of a write -> outputs 0 next cycle, subsequent read returns old data.
